// File: rtl/pattern_gen_pkg.sv
// Shared definitions for the multi-channel test-pattern source:
// pattern modes, LFSR constants and small helpers for the LFSR sequence.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP   = 2'd0,
    MODE_CONST  = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_LFSR   = 2'd3
  } mode_t;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

  // Each channel starts from a distinct seed so channels are decorrelated.
  function automatic logic [15:0] channel_seed(input int unsigned ch);
    return LFSR_SEED ^ 16'(ch);
  endfunction

endpackage

// File: rtl/pattern_channel.sv
// One pattern generator channel. Holds the ramp accumulator, square-wave
// phase and LFSR state; advances only the state of the active mode on a tick.
// value is the sample that a tick occurring this cycle would present.
module pattern_channel
  import pattern_gen_pkg::*;
#(
  parameter int SAMPLE_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                clr,
  input  mode_t               mode,
  input  logic [SAMPLE_W-1:0] step,
  input  logic [15:0]         seed,
  output logic [SAMPLE_W-1:0] value
);

  logic [SAMPLE_W-1:0] acc;
  logic                phase;
  logic [15:0]         lfsr;

  // Generator state: cleared by reset or while the block is disabled,
  // otherwise advanced one step per tick in the selected mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      phase <= 1'b0;
      lfsr  <= seed;
    end else if (clr) begin
      acc   <= '0;
      phase <= 1'b0;
      lfsr  <= seed;
    end else if (tick) begin
      case (mode)
        MODE_RAMP:   acc   <= acc + step;
        MODE_SQUARE: phase <= ~phase;
        MODE_LFSR:   lfsr  <= lfsr_next(lfsr);
        default:     ;
      endcase
    end
  end

  // Current sample value for the selected mode.
  always_comb begin
    value = '0;
    case (mode)
      MODE_RAMP:   value = acc;
      MODE_CONST:  value = step;
      MODE_SQUARE: value = phase ? step : '0;
      MODE_LFSR:   value = lfsr[SAMPLE_W-1:0];
      default:     value = '0;
    endcase
  end

endmodule

// File: rtl/pattern_sample_gen.sv
// Multi-channel test-pattern sample source. A rate counter produces ticks;
// each tick packs one sample per channel into a word that is offered on a
// valid/ready output. Accepted words are counted and dropped ticks are
// flagged in a sticky overflow bit.
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_valid and out_data are held; a tick arriving then is dropped.
module pattern_sample_gen
  import pattern_gen_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 12,
  parameter int SLOT_W   = 16,
  parameter int RATE_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [RATE_W-1:0]          rate_div,
  input  logic [NUM_CH*SAMPLE_W-1:0] step,
  input  logic                       clear_stats,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [NUM_CH*SLOT_W-1:0]   out_data,
  output logic [31:0]                sample_count,
  output logic                       overflow
);

  logic [RATE_W-1:0]          rate_cnt;
  logic                       tick;
  logic                       gen_clr;
  logic                       handshake;
  logic                       load;
  logic                       drop;
  mode_t                      mode_sel;
  logic [NUM_CH*SAMPLE_W-1:0] ch_value;
  logic [NUM_CH*SLOT_W-1:0]   packed_word;

  assign mode_sel  = mode_t'(mode);
  assign gen_clr   = !enable;
  // >= rather than == so a rate_div lowered below the running count
  // does not stall generation for a full counter wrap.
  assign tick      = enable && (rate_cnt >= rate_div);
  assign handshake = out_valid && out_ready;
  assign load      = tick && (!out_valid || out_ready);
  assign drop      = tick && out_valid && !out_ready;

  // Rate counter: counts enabled cycles, restarts on each tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate_cnt <= '0;
    end else if (!enable || tick) begin
      rate_cnt <= '0;
    end else begin
      rate_cnt <= rate_cnt + RATE_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pattern_channel #(
      .SAMPLE_W (SAMPLE_W)
    ) u_channel (
      .clk   (clk),
      .rst   (reset),
      .tick  (tick),
      .clr   (gen_clr),
      .mode  (mode_sel),
      .step  (step[k*SAMPLE_W +: SAMPLE_W]),
      .seed  (channel_seed(k)),
      .value (ch_value[k*SAMPLE_W +: SAMPLE_W])
    );
  end

  // Pack channel samples into their slots, zeroing the pad bits.
  always_comb begin
    packed_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      packed_word[k*SLOT_W +: SAMPLE_W] = ch_value[k*SAMPLE_W +: SAMPLE_W];
    end
  end

  // Output register: load on an accepted tick, retire after a handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= packed_word;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Accepted-word counter; a clear in the same cycle wins over a handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_count <= '0;
    end else if (clear_stats) begin
      sample_count <= '0;
    end else if (handshake) begin
      sample_count <= sample_count + 32'd1;
    end
  end

  // Sticky drop flag; a drop in the same cycle wins over a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_stats) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pattern_sample_gen.sv
// Bench for pattern_sample_gen: directed scenarios plus randomized segments,
// all checked cycle by cycle against a behavioural model of the sample source.
module tb_pattern_sample_gen;

  localparam int NUM_CH   = 2;
  localparam int SAMPLE_W = 12;
  localparam int SLOT_W   = 16;
  localparam int RATE_W   = 16;
  localparam int DW       = NUM_CH * SLOT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       reset;
  logic                       enable;
  logic [1:0]                 mode;
  logic [RATE_W-1:0]          rate_div;
  logic [NUM_CH*SAMPLE_W-1:0] step;
  logic                       clear_stats;
  logic                       out_ready;
  logic                       out_valid;
  logic [DW-1:0]              out_data;
  logic [31:0]                sample_count;
  logic                       overflow;

  pattern_sample_gen #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W),
    .SLOT_W   (SLOT_W),
    .RATE_W   (RATE_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .mode         (mode),
    .rate_div     (rate_div),
    .step         (step),
    .clear_stats  (clear_stats),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .sample_count (sample_count),
    .overflow     (overflow)
  );

  // ---------------- reference model ----------------
  int unsigned         m_cnt;
  logic [SAMPLE_W-1:0] m_acc   [NUM_CH];
  bit                  m_phase [NUM_CH];
  logic [15:0]         m_lfsr  [NUM_CH];
  bit                  m_valid;
  logic [DW-1:0]       m_data;
  logic [31:0]         m_count;
  bit                  m_ovf;
  logic [DW-1:0]       exp_q[$];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [SAMPLE_W-1:0] ch_step(input int ch);
    return step[ch*SAMPLE_W +: SAMPLE_W];
  endfunction

  function automatic logic [SAMPLE_W-1:0] gen_value(input int ch);
    case (mode)
      2'd0:    return m_acc[ch];
      2'd1:    return ch_step(ch);
      2'd2:    return m_phase[ch] ? ch_step(ch) : '0;
      default: return m_lfsr[ch][SAMPLE_W-1:0];
    endcase
  endfunction

  task automatic gen_clear();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_acc[ch]   = '0;
      m_phase[ch] = 1'b0;
      m_lfsr[ch]  = 16'hACE1 ^ 16'(ch);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_count = '0;
    m_ovf   = 1'b0;
    gen_clear();
    exp_q.delete();
  endtask

  // ---------------- driver: advance one clock ----------------
  // Inputs are already set for this cycle. The model consumes them, the
  // clock edge occurs, and all outputs are compared one time unit later.
  task automatic step_cycle();
    bit            tick;
    bit            hs;
    bit            drop;
    logic [DW-1:0] w;
    // scoreboard: every word the DUT hands over must be the next expected one
    if (out_valid && out_ready) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("sb_word", out_data, exp_q.pop_front());
    end
    tick = enable && (m_cnt == rate_div);
    hs   = m_valid && out_ready;
    drop = tick && m_valid && !out_ready;
    w = '0;
    for (int ch = 0; ch < NUM_CH; ch++) w[ch*SLOT_W +: SAMPLE_W] = gen_value(ch);
    if (clear_stats) m_count = '0;
    else if (hs)     m_count = m_count + 32'd1;
    if (drop)             m_ovf = 1'b1;
    else if (clear_stats) m_ovf = 1'b0;
    if (tick && !drop) begin
      m_data  = w;
      m_valid = 1'b1;
      exp_q.push_back(w);
    end else if (!tick && out_ready) begin
      m_valid = 1'b0;
    end
    if (!enable) begin
      gen_clear();
    end else if (tick) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        case (mode)
          2'd0: m_acc[ch] = m_acc[ch] + ch_step(ch);
          2'd2: m_phase[ch] = !m_phase[ch];
          2'd3: m_lfsr[ch] = (m_lfsr[ch] >> 1) ^ (m_lfsr[ch][0] ? 16'hB400 : 16'h0000);
          default: ;
        endcase
      end
    end
    if (!enable || tick) m_cnt = 0;
    else                 m_cnt = m_cnt + 1;
    @(posedge clk);
    #1;
    check("valid", out_valid, m_valid);
    check("data", out_data, m_data);
    check("count", sample_count, m_count);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic idle_cycles(input int n);
    enable = 1'b0;
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    mode        = 2'd0;
    rate_div    = '0;
    step        = '0;
    clear_stats = 1'b0;
    out_ready   = 1'b1;
    model_reset();
    #2;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_count", sample_count, '0);
    check("rst_overflow", overflow, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // RAMP, step ch1=16 ch0=1, full rate, including ch0 wrap at sample 4096
    mode = 2'd0;
    step = {12'd16, 12'd1};
    enable = 1'b1;
    for (int i = 1; i <= 4097; i++) begin
      step_cycle();
      if (i == 1)    check("ramp_w0", out_data, 32'h0000_0000);
      if (i == 2)    check("ramp_w1", out_data, 32'h0010_0001);
      if (i == 3)    check("ramp_w2", out_data, 32'h0020_0002);
      if (i == 4096) check("ramp_w4095", out_data, 32'h0FF0_0FFF);
      if (i == 4097) check("ramp_wrap", out_data, 32'h0000_0000);
      if (i >= 2)    check("ramp_b2b_valid", out_valid, 1'b1);
    end
    check("ramp_count", sample_count, 32'd4096);
    idle_cycles(2);

    // rate_div = 3: one word every 4 cycles
    rate_div = 16'd3;
    clear_stats = 1'b1;
    step_cycle();
    clear_stats = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step_cycle();
      check("rate_valid", out_valid, (i % 4) == 0);
    end
    check("rate_count", sample_count, 32'd2);
    idle_cycles(2);

    // backpressure: word 0 held, ticks dropped, clear coincident with a drop
    rate_div = '0;
    step = {12'd0, 12'd1};
    out_ready = 1'b0;
    enable = 1'b1;
    step_cycle();
    check("bp_first_valid", out_valid, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      clear_stats = (i == 5);
      step_cycle();
      check("bp_hold", out_data, 32'h0000_0000);
      check("bp_ovf", overflow, 1'b1);
      if (i == 5) check("bp_clear_count", sample_count, 32'd0);
    end
    clear_stats = 1'b0;
    out_ready = 1'b1;
    step_cycle();
    check("bp_resume", out_data, 32'h0000_000B);
    idle_cycles(2);

    // CONST
    mode = 2'd1;
    step = {12'h123, 12'h456};
    enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step_cycle();
      check("const_word", out_data, 32'h0123_0456);
    end
    idle_cycles(2);

    // SQUARE, ch0 level 0x7FF
    mode = 2'd2;
    step = {12'h0AB, 12'h7FF};
    enable = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step_cycle();
      check("square_ch0", out_data[11:0], (i % 2 == 0) ? 12'h7FF : 12'h000);
    end
    idle_cycles(2);

    // LFSR
    mode = 2'd3;
    enable = 1'b1;
    step_cycle();
    check("lfsr_w0", out_data, 32'h0CE0_0CE1);
    step_cycle();
    check("lfsr_w1", out_data, 32'h0670_0270);
    idle_cycles(2);

    // randomized segments
    for (int seg = 0; seg < 30; seg++) begin
      enable   = 1'b0;
      rate_div = RATE_W'($urandom_range(0, 3));
      step_cycle();
      mode = 2'($urandom_range(0, 3));
      step = {12'($urandom), 12'($urandom)};
      for (int c = 0; c < int'($urandom_range(20, 80)); c++) begin
        enable      = ($urandom_range(0, 49) != 0);
        out_ready   = ($urandom_range(0, 3) != 0);
        clear_stats = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
        step_cycle();
      end
      clear_stats = 1'b0;
    end
    out_ready = 1'b1;
    idle_cycles(2);

    // reset in the middle of a stalled transfer
    mode = 2'd0;
    rate_div = '0;
    step = {12'd2, 12'd1};
    enable = 1'b1;
    for (int i = 0; i < 5; i++) step_cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step_cycle();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_count", sample_count, '0);
    check("mid_rst_ovf", overflow, 1'b0);
    check("mid_rst_data", out_data, '0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    step_cycle();
    check("restart_w0", out_data, 32'h0000_0000);
    step_cycle();
    check("restart_w1", out_data, 32'h0002_0001);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
